id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline boundary of the 5-stage MIPS core, directly downstream of the main control decoder. Registers the nine decoder control bits, the operands and the register specifiers into EX. Detects load-use hazards and replaces the ID instruction with a bubble while freezing PC and IF/ID. Honors a branch flush from MEM and keeps saturating performance counters for stalls and flushes.

## Interface
Parameters:
- DATA_W, 32, operand/PC width
- REG_W, 5, register specifier width
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_ctrl  in  9  decoder bundle {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}, MSB first
- id_pc_plus4  in  DATA_W  PC+4 of ID instruction
- id_rd1, id_rd2  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_W  instruction fields [25:21], [20:16], [15:11]
- flush  in  1  branch taken in MEM; kill instruction entering EX
- ex_ctrl  out  9  registered control bundle, same bit order
- ex_pc_plus4, ex_rd1, ex_rd2, ex_imm  out  DATA_W  registered data
- ex_rs, ex_rt, ex_rd  out  REG_W  registered specifiers
- pc_write  out  1  0 = hold PC this cycle
- if_id_write  out  1  0 = hold IF/ID this cycle
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Hazard (combinational): hazard = ex_ctrl.MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)) & ~flush.
- pc_write = if_id_write = ~hazard.
- The register loads every cycle. No global enable.
- Load value selection, by priority:
  - reset: all outputs zero.
  - flush: ex_ctrl = 0; data/specifier fields load ID values (don't-care, but deterministic).
  - hazard: ex_ctrl = 0 (bubble); data fields load ID values.
  - otherwise: all fields load ID inputs.
- Bubble: zero ex_ctrl means RegWrite = MemWrite = MemRead = Branch = 0, so no architectural effect.
- stall_cnt increments on each hazard cycle. flush_cnt increments on each flush cycle. Both saturate at all-ones and never wrap.
- Flush plus hazard in the same cycle: flush wins.
  - pc_write = 1, so the branch redirect can load the PC.
  - stall_cnt is not incremented; flush_cnt is.
- A bubble resulting from a hazard clears ex_ctrl.MemRead. The same ID instruction therefore cannot stall twice for the same load, so a load-use stall is exactly one cycle.
- ex_rt == 0 never stalls ($zero is never a real dependency).

## Timing
- Latency: ID inputs appear on ex_* one cycle after the capturing edge.
- pc_write/if_id_write are valid in the same cycle as the ID inputs. They depend only on current ex_* registers, id_rs/id_rt and flush; no registered delay.
- Reset values: every output zero except pc_write = if_id_write = 1.
- Reset asserted mid-stall: the next cycle shows ex_ctrl = 0, counters = 0, pc_write = 1.
- Reset dominates flush and hazard on the same edge.
- Counters update on the same edge that captures the bubble.

## Structure
- Shared package mips_pkg holds:
  - CTRL_W = 9
  - bit-position constants for the control bundle (CTRL_REGDST = 8 … CTRL_ALUOP_LSB = 0)
  - CTRL_BUBBLE = 9'b0
- The decoder and this stage must both use that package.
- One combinational sub-module, hazard_detect, computes hazard from ex_memread, ex_rt, id_rs, id_rt and flush. The forwarding unit reuses it later.
- The top level contains the register bank, bubble mux and counters.

## Test plan
- R-type pass-through: id_ctrl = 9'b100100010, id_rd1 = 0x11, id_rs = 3, no hazard → next cycle ex_ctrl = 9'b100100010, ex_rd1 = 0x11, ex_rs = 3; pc_write = 1.
- Load-use: EX holds LW (ex_ctrl = 9'b011110000, ex_rt = 8); ID has id_rs = 8 → pc_write = if_id_write = 0 that cycle; next ex_ctrl = 0; stall_cnt = 1; the following cycle pc_write = 1.
- $zero exemption: EX LW with ex_rt = 0, id_rs = 0 → no stall, stall_cnt unchanged.
- Flush: flush = 1 with id_ctrl = 9'b010001000 (SW) → next ex_ctrl = 0; flush_cnt = 1.
- Flush plus hazard simultaneously → pc_write = 1; next ex_ctrl = 0; flush_cnt +1; stall_cnt unchanged.
- Saturation and reset: force 65535 + 2 hazard cycles → stall_cnt = 16'hFFFF; then assert reset for one cycle → all ex_* = 0, counters = 0, pc_write = 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: control-bundle layout used by the main
// decoder and by the ID/EX pipeline register.
package mips_pkg;

   localparam int CTRL_W = 9;

   // Bit positions inside the decoder control bundle (MSB first)
   localparam int CTRL_REGDST    = 8;
   localparam int CTRL_ALUSRC    = 7;
   localparam int CTRL_MEMTOREG  = 6;
   localparam int CTRL_REGWRITE  = 5;
   localparam int CTRL_MEMREAD   = 4;
   localparam int CTRL_MEMWRITE  = 3;
   localparam int CTRL_BRANCH    = 2;
   localparam int CTRL_ALUOP_MSB = 1;
   localparam int CTRL_ALUOP_LSB = 0;

   typedef logic [CTRL_W-1:0] ctrl_t;

   // All-zero bundle: no register write, no memory access, no branch
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage : mips_pkg

// File: rtl/hazard_detect.sv
// Load-use hazard detector. Purely combinational; a flush in MEM
// suppresses the stall so the branch redirect can proceed.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic             i_ex_memread,
   input  logic [REG_W-1:0] i_ex_rt,
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_flush,
   output logic             o_hazard
);

   logic w_rt_nonzero;
   logic w_match;

   // Compare the load destination against both ID source specifiers
   always_comb begin
      w_rt_nonzero = (i_ex_rt != '0);
      w_match      = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
      o_hazard     = i_ex_memread && w_rt_nonzero && w_match && !i_flush;
   end

endmodule : hazard_detect

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush
// and saturating stall/flush event counters.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [DATA_W-1:0] id_pc_plus4,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              flush,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DATA_W-1:0] ex_pc_plus4,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic              pc_write,
   output logic              if_id_write,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic [CTRL_W-1:0] r_ex_ctrl;
   logic [DATA_W-1:0] r_ex_pc_plus4;
   logic [DATA_W-1:0] r_ex_rd1;
   logic [DATA_W-1:0] r_ex_rd2;
   logic [DATA_W-1:0] r_ex_imm;
   logic [REG_W-1:0]  r_ex_rs;
   logic [REG_W-1:0]  r_ex_rt;
   logic [REG_W-1:0]  r_ex_rd;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;
   logic              w_hazard;

   hazard_detect #(
      .REG_W(REG_W)
   ) u_hazard_detect (
      .i_ex_memread(r_ex_ctrl[CTRL_MEMREAD]),
      .i_ex_rt     (r_ex_rt),
      .i_id_rs     (id_rs),
      .i_id_rt     (id_rt),
      .i_flush     (flush),
      .o_hazard    (w_hazard)
   );

   // Pipeline register: bubble the control bits on flush or load-use stall
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_ctrl     <= CTRL_BUBBLE;
         r_ex_pc_plus4 <= '0;
         r_ex_rd1      <= '0;
         r_ex_rd2      <= '0;
         r_ex_imm      <= '0;
         r_ex_rs       <= '0;
         r_ex_rt       <= '0;
         r_ex_rd       <= '0;
      end else begin
         r_ex_ctrl     <= (flush || w_hazard) ? CTRL_BUBBLE : id_ctrl;
         r_ex_pc_plus4 <= id_pc_plus4;
         r_ex_rd1      <= id_rd1;
         r_ex_rd2      <= id_rd2;
         r_ex_imm      <= id_imm;
         r_ex_rs       <= id_rs;
         r_ex_rt       <= id_rt;
         r_ex_rd       <= id_rd;
      end
   end

   // Saturating stall and flush event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_hazard && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   // Drive outputs from registers; freeze PC and IF/ID during a stall
   always_comb begin
      ex_ctrl     = r_ex_ctrl;
      ex_pc_plus4 = r_ex_pc_plus4;
      ex_rd1      = r_ex_rd1;
      ex_rd2      = r_ex_rd2;
      ex_imm      = r_ex_imm;
      ex_rs       = r_ex_rs;
      ex_rt       = r_ex_rt;
      ex_rd       = r_ex_rd;
      stall_cnt   = r_stall_cnt;
      flush_cnt   = r_flush_cnt;
      pc_write    = !w_hazard;
      if_id_write = !w_hazard;
   end

endmodule : id_ex_stage
